// File: rtl/verificar_ganador.sv
// verificar_ganador: serial tic-tac-toe winner/draw checker, scanning one board line per clock.
// Define VERIFICAR_GANADOR_EARLY_EXIT_EN to end the scan in the cycle after the first winning line.
module verificar_ganador #(
    parameter int unsigned HOLD_RESULT = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [17:0] board_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  winner_o,
    output logic [2:0]  win_line_o,
    output logic        draw_o
);
    localparam int unsigned CellW  = 2;
    localparam int unsigned NCells = 9;
    localparam int unsigned BoardW = CellW * NCells;
    localparam int unsigned CntW   = 4;
    localparam int unsigned LineW  = 3;
    localparam logic [CntW-1:0] LastCnt = CntW'(8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [BoardW-1:0]   snap_q, snap_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                found_q, found_d;
    logic [CellW-1:0]    player_q, player_d;
    logic [LineW-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CellW-1:0]    winner_q, winner_d;
    logic [LineW-1:0]    win_line_q, win_line_d;
    logic                draw_q, draw_d;

    logic [CellW-1:0]    cells_c [NCells];
    logic [CellW-1:0]    ca_c, cb_c, cc_c;
    logic                line_win_c;
    logic                board_full_c;
    logic                scan_end_c;

    // Unpack the captured snapshot into cells 0..8 (board cells 1..9).
    always_comb begin
        for (int unsigned n = 0; n < NCells; n++) begin
            cells_c[n] = snap_q[n*CellW +: CellW];
        end
    end

    // Select the three cells of the line addressed by the counter.
    always_comb begin
        ca_c = cells_c[0];
        cb_c = cells_c[1];
        cc_c = cells_c[2];
        case (cnt_q[LineW-1:0])
            3'd0: begin ca_c = cells_c[0]; cb_c = cells_c[1]; cc_c = cells_c[2]; end
            3'd1: begin ca_c = cells_c[3]; cb_c = cells_c[4]; cc_c = cells_c[5]; end
            3'd2: begin ca_c = cells_c[6]; cb_c = cells_c[7]; cc_c = cells_c[8]; end
            3'd3: begin ca_c = cells_c[0]; cb_c = cells_c[3]; cc_c = cells_c[6]; end
            3'd4: begin ca_c = cells_c[1]; cb_c = cells_c[4]; cc_c = cells_c[7]; end
            3'd5: begin ca_c = cells_c[2]; cb_c = cells_c[5]; cc_c = cells_c[8]; end
            3'd6: begin ca_c = cells_c[0]; cb_c = cells_c[4]; cc_c = cells_c[8]; end
            3'd7: begin ca_c = cells_c[2]; cb_c = cells_c[4]; cc_c = cells_c[6]; end
            default: ;
        endcase
    end

    assign line_win_c = (ca_c == cb_c) && (cb_c == cc_c) &&
                        ((ca_c == 2'b01) || (ca_c == 2'b10));

    always_comb begin
        board_full_c = 1'b1;
        for (int unsigned n = 0; n < NCells; n++) begin
            if (cells_c[n] == 2'b00) board_full_c = 1'b0;
        end
    end

`ifdef VERIFICAR_GANADOR_EARLY_EXIT_EN
    assign scan_end_c = (cnt_q == LastCnt) || found_q;
`else
    assign scan_end_c = (cnt_q == LastCnt);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SCAN;
            SCAN:    if (scan_end_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        found_d    = found_q;
        player_d   = player_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        winner_d   = winner_q;
        win_line_d = win_line_q;
        draw_d     = draw_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    snap_d     = board_i;
                    cnt_d      = '0;
                    found_d    = 1'b0;
                    player_d   = '0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    winner_d   = '0;
                    win_line_d = '0;
                    draw_d     = 1'b0;
                end
            end
            SCAN: begin
                if (scan_end_c) begin
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    winner_d   = found_q ? player_q : 2'b00;
                    win_line_d = found_q ? idx_q : 3'd0;
                    draw_d     = !found_q && board_full_c;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (!found_q && line_win_c) begin
                        found_d  = 1'b1;
                        player_d = ca_c;
                        idx_d    = cnt_q[LineW-1:0];
                    end
                end
            end
            DONE: begin
                if (HOLD_RESULT == 0) begin
                    winner_d   = '0;
                    win_line_d = '0;
                    draw_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q     <= '0;
            cnt_q      <= '0;
            found_q    <= 1'b0;
            player_q   <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            winner_q   <= '0;
            win_line_q <= '0;
            draw_q     <= 1'b0;
        end else begin
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            found_q    <= found_d;
            player_q   <= player_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            winner_q   <= winner_d;
            win_line_q <= win_line_d;
            draw_q     <= draw_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign winner_o   = winner_q;
    assign win_line_o = win_line_q;
    assign draw_o     = draw_q;

endmodule

// File: tb/tb_verificar_ganador.sv
// Bench for verificar_ganador: holding and clearing instances share stimulus and are
// checked each cycle against a board-level reference model plus literal expectations.
module tb_verificar_ganador;
`ifdef VERIFICAR_GANADOR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [17:0] board = '0;

    logic       busy_h, done_h, draw_h, busy_c, done_c, draw_c;
    logic [1:0] winner_h, winner_c;
    logic [2:0] line_h, line_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    verificar_ganador #(.HOLD_RESULT(1)) u_dut_hold (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .board_i(board),
        .busy_o(busy_h), .done_o(done_h), .winner_o(winner_h),
        .win_line_o(line_h), .draw_o(draw_h)
    );

    verificar_ganador #(.HOLD_RESULT(0)) u_dut_clr (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .board_i(board),
        .busy_o(busy_c), .done_o(done_c), .winner_o(winner_c),
        .win_line_o(line_c), .draw_o(draw_c)
    );

    int line_cells [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                              '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Game rules: {winner[9:8], line[7:5], draw[4], latency in cycles[3:0]}.
    function automatic logic [9:0] eval_board(input logic [17:0] b);
        logic [1:0] c [1:9];
        logic       found;
        logic       full;
        logic [1:0] w;
        int         ln;
        int         lat;
        found = 1'b0; full = 1'b1; w = 2'b00; ln = 0;
        for (int n = 1; n <= 9; n++) begin
            c[n] = b[2*n-1 -: 2];
            if (c[n] == 2'b00) full = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            logic [1:0] a0, a1, a2;
            a0 = c[line_cells[i][0]];
            a1 = c[line_cells[i][1]];
            a2 = c[line_cells[i][2]];
            if (!found && a0 == a1 && a1 == a2 && (a0 == 2'b01 || a0 == 2'b10)) begin
                found = 1'b1; w = a0; ln = i;
            end
        end
        lat = (EARLY && found) ? ln + 2 : 9;
        return {w, 3'(ln), !found && full, 4'(lat)};
    endfunction

    // Transaction-level expectations for the holding instance.
    logic       m_busy = 0, m_done = 0, m_d = 0;
    logic [1:0] m_w = 0;
    logic [2:0] m_l = 0;
    logic [9:0] m_res = 0;
    int         m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_w <= 0; m_l <= 0; m_d <= 0; m_cnt <= 0; m_res <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (m_busy) begin
            if (m_cnt == int'(m_res[3:0])) begin
                m_busy <= 0; m_done <= 1;
                m_w <= m_res[9:8]; m_l <= m_res[7:5]; m_d <= m_res[4];
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (start) begin
            m_res <= eval_board(board);
            m_busy <= 1; m_cnt <= 1; m_w <= 0; m_l <= 0; m_d <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc busy_h", int'(busy_h), int'(m_busy));
            chk("cyc done_h", int'(done_h), int'(m_done));
            chk("cyc winner_h", int'(winner_h), int'(m_w));
            chk("cyc line_h", int'(line_h), int'(m_l));
            chk("cyc draw_h", int'(draw_h), int'(m_d));
            chk("cyc busy_c", int'(busy_c), int'(m_busy));
            chk("cyc done_c", int'(done_c), int'(m_done));
            chk("cyc winner_c", int'(winner_c), m_done ? int'(m_w) : 0);
            chk("cyc line_c", int'(line_c), m_done ? int'(m_l) : 0);
            chk("cyc draw_c", int'(draw_c), m_done ? int'(m_d) : 0);
        end
    end

    // Called at a negedge: start pulse, bounded wait for done, literal checks.
    task automatic run_case(input string nm, input logic [17:0] b, input logic [1:0] ew,
                            input logic [2:0] el, input logic ed, input int elat);
        int cyc;
        logic [9:0] pin;
        pin = eval_board(b);
        chk({nm, " model"}, int'(pin), int'({ew, el, ed, 4'(elat)}));
        board = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done_h && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (!done_h) begin
            chk({nm, " timeout"}, 0, 1);
            return;
        end
        chk({nm, " latency"}, cyc, elat);
        chk({nm, " winner_h"}, int'(winner_h), int'(ew));
        chk({nm, " line_h"}, int'(line_h), int'(el));
        chk({nm, " draw_h"}, int'(draw_h), int'(ed));
        chk({nm, " winner_c"}, int'(winner_c), int'(ew));
        chk({nm, " draw_c"}, int'(draw_c), int'(ed));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " done low"}, int'(done_h), 0);
        chk({nm, " start in done ignored"}, int'(busy_h), 0);
        chk({nm, " hold winner"}, int'(winner_h), int'(ew));
        chk({nm, " hold draw"}, int'(draw_h), int'(ed));
        chk({nm, " clr winner"}, int'(winner_c), 0);
        chk({nm, " clr draw"}, int'(draw_c), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int pulses;
        int done_at;
        logic [1:0] w_seen;
        logic d_seen;

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy_h), 0);
        chk("reset done", int'(done_h), 0);
        chk("reset winner", int'(winner_h), 0);
        chk("reset draw", int'(draw_c), 0);
        rst_n = 1'b1;

        run_case("row0 p0", 18'h00015, 2'b01, 3'd0, 1'b0, EARLY ? 2 : 9);
        run_case("diag7 p1", 18'h02220, 2'b10, 3'd7, 1'b0, 9);
        run_case("full draw", 18'h16A59, 2'b00, 3'd0, 1'b1, 9);
        run_case("two wins", 18'h01055, 2'b01, 3'd0, 1'b0, EARLY ? 2 : 9);
        run_case("col4 p1", 18'h08208, 2'b10, 3'd4, 1'b0, EARLY ? 6 : 9);
        run_case("illegal", 18'h3FFFF, 2'b00, 3'd0, 1'b1, 9);

        // Board change and second start while busy are both ignored.
        board = 18'h00019; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        board = 18'h00015; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; done_at = -1; w_seen = 2'b11; d_seen = 1'b1;
        for (int i = 3; i < 20; i++) begin
            if (done_h) begin
                pulses++; done_at = i - 1; w_seen = winner_h; d_seen = draw_h;
            end
            @(negedge clk);
        end
        chk("ignore pulses", pulses, 1);
        chk("ignore latency", done_at, 9);
        chk("ignore winner", int'(w_seen), 0);
        chk("ignore draw", int'(d_seen), 0);

        // Reset in the middle of a scan, after line 3.
        board = 18'h02220; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy_h", int'(busy_h), 0);
        chk("midrst done_h", int'(done_h), 0);
        chk("midrst winner_h", int'(winner_h), 0);
        chk("midrst line_h", int'(line_h), 0);
        chk("midrst draw_h", int'(draw_h), 0);
        chk("midrst busy_c", int'(busy_c), 0);
        @(negedge clk);
        chk("midrst still idle", int'(busy_h), 0);
        rst_n = 1'b1;
        run_case("after reset", 18'h00015, 2'b01, 3'd0, 1'b0, EARLY ? 2 : 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/verificar_ganador.md
VERIFICAR_GANADOR -- requirements
Module: verificar_ganador

Interface
REQ-001 The block SHALL have one parameter: HOLD_RESULT, default 1; 1 = result outputs held until next start, 0 = result outputs cleared on return to IDLE.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to evaluate board after a validated move; sampled only in IDLE.
REQ-005 board  input  18  board snapshot; cell n (1..9) = board[2n-1:2n-2]; 00 empty, 01 player 0, 10 player 1, 11 illegal.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 done  output  1  one-cycle pulse when the result is valid.
REQ-008 winner  output  2  00 none, 01 player 0, 10 player 1; 11 never driven.
REQ-009 win_line  output  3  index of the winning line; 0 when winner = 00.
REQ-010 draw  output  1  high when no winner and no empty cell.

Function
REQ-011 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-012 IDLE with start = 1: board SHALL be latched into an internal snapshot, line counter set to 0, next state SCAN.
REQ-013 The block SHALL ignore board changes after capture and SHALL ignore start outside IDLE.
REQ-014 SCAN evaluates one line per cycle in fixed order: 0 = cells 1-2-3, 1 = 4-5-6, 2 = 7-8-9, 3 = 1-4-7, 4 = 2-5-8, 5 = 3-6-9, 6 = 1-5-9, 7 = 3-5-7.
REQ-015 A line wins when all three cells are equal and equal to 01 or 10; 00 and 11 never win.
REQ-016 The first winning line in scan order SHALL set winner and win_line; later winning lines SHALL NOT overwrite them.
REQ-017 After line 7 with no winner, draw SHALL be 1 if no snapshot cell is 00, else 0; a cell of 11 counts as non-empty.
REQ-018 SCAN exits to DONE after line 7, or earlier per REQ-026.
REQ-019 DONE SHALL assert done for exactly one cycle with winner, win_line and draw valid in that cycle, then return to IDLE.
REQ-020 Full-scan latency: start sampled at edge k; done high during the cycle after edge k+9.
REQ-021 With HOLD_RESULT = 1, winner, win_line and draw SHALL keep their values until the next accepted start, which clears them at edge k.
REQ-022 With HOLD_RESULT = 0, these outputs SHALL be 0 whenever done is 0.
REQ-023 A start in the DONE cycle SHALL be ignored; the next start is accepted in IDLE.

Reset
REQ-024 When reset is low, the block SHALL immediately force state IDLE and busy, done, winner, win_line, draw, the snapshot and the line counter to 0, including mid-SCAN.
REQ-025 After reset is released, the first start SHALL be accepted at the first rising edge.

Configuration
REQ-026 With macro VERIFICAR_GANADOR_EARLY_EXIT_EN defined, SCAN SHALL go to DONE in the cycle after the first winning line.
- Win on line i: done high during the cycle after edge k+i+2.
- No win: latency stays per REQ-020.
REQ-027 Without the macro, all 8 lines SHALL always be scanned and latency SHALL be fixed per REQ-020; winner and win_line values are identical in both builds.

Verification
REQ-028 Reset low mid-SCAN (after line 3) -> busy, done, winner, win_line and draw read 0 immediately; a start after release completes normally.
REQ-029 board = 18'h00015, start pulse -> winner = 01, win_line = 0, draw = 0; done at k+2 with EARLY_EXIT, else at k+9.
REQ-030 board = 18'h02220, start -> winner = 10, win_line = 7, draw = 0.
REQ-031 board = 18'h16A59 (X O X / X O O / O X X), start -> winner = 00, win_line = 0, draw = 1, done at k+9.
REQ-032 board = 18'h00019, start, then board changed to 18'h00015 and a second start pulsed during busy -> winner = 00, draw = 0, exactly one done pulse.
REQ-033 board = 18'h3FFFF (all cells illegal), start -> winner = 00, draw = 1; then HOLD_RESULT = 0 build -> outputs 0 one cycle after done.
